// File: rtl/crc16_checker.sv
// Receive-side CRC-16 (0x1021, MSB-first) checker: strips the trailing 2-byte CRC, forwards payload, reports pass/fail.
// Optional frame statistics (good_cnt/bad_cnt) are built when CRC16_CHK_STATS_EN is defined.
module crc16_checker #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        init,
    input  logic [7:0]  seed,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        done,
    output logic        crc_ok,
    output logic        len_err,
    output logic [15:0] crc_rx,
    output logic [15:0] crc_calc
`ifdef CRC16_CHK_STATS_EN
    ,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, CHECK} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [7:0]  h0, h1;
    logic [15:0] crc;
    logic        live;
    logic        acc, emit, chk_fire, ok_now;

    // Same byte step as the transmit generator: table value T(x) built by 8 shift/xor rounds.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] t;
        t = {d ^ c[15:8], 8'h00};
        for (int i = 0; i < 8; i++)
            t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
        return {c[7:0], 8'h00} ^ t;
    endfunction

    // live holds s_ready low until the first edge after reset release.
    always_comb begin
        s_ready = 1'b0;
        if (live) begin
            case (state)
                IDLE, FILL: s_ready = 1'b1;
                STREAM:     s_ready = !m_valid || m_ready;
                default:    s_ready = 1'b0;
            endcase
        end
    end

    assign acc      = s_valid && s_ready;
    assign emit     = acc && !init && (state == STREAM);
    assign chk_fire = (state == CHECK) && !init;
    assign ok_now   = (crc == crc_rx) && !len_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            h0       <= 8'h00;
            h1       <= 8'h00;
            crc      <= {8'h00, seed};
            live     <= 1'b0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            len_err  <= 1'b0;
            crc_rx   <= 16'h0000;
            crc_calc <= 16'h0000;
        end else begin
            live <= 1'b1;
            done <= 1'b0;
            if (init) begin
                state   <= IDLE;
                cnt     <= 2'd0;
                h0      <= 8'h00;
                h1      <= 8'h00;
                len_err <= 1'b0;
                crc     <= {8'h00, seed};
            end else begin
                case (state)
                    IDLE, FILL: begin
                        if (acc) begin
                            if (state == IDLE)
                                len_err <= 1'b0;
                            if (s_last) begin
                                len_err <= 1'b1;
                                state   <= CHECK;
                            end else begin
                                h0    <= h1;
                                h1    <= s_data;
                                cnt   <= 2'(cnt + 2'd1);
                                state <= (state == IDLE) ? FILL : STREAM;
                            end
                        end
                    end
                    STREAM: begin
                        if (acc) begin
                            crc <= crc_step(crc, h0);
                            if (s_last) begin
                                crc_rx <= {h1, s_data};
                                state  <= CHECK;
                            end else begin
                                h0 <= h1;
                                h1 <= s_data;
                            end
                        end
                    end
                    default: begin
                        crc_calc <= crc;
                        crc_ok   <= ok_now;
                        done     <= 1'b1;
                        crc      <= {8'h00, seed};
                        cnt      <= 2'd0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output register is independent of init so an already-emitted byte still drains.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (emit) begin
            m_data  <= h0;
            m_valid <= 1'b1;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

`ifdef CRC16_CHK_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (chk_fire) begin
            if (ok_now && (good_cnt != '1))
                good_cnt <= good_cnt + CNT_W'(1);
            if (!ok_now && (bad_cnt != '1))
                bad_cnt <= bad_cnt + CNT_W'(1);
        end
    end
`else
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule

// File: tb/tb_crc16_checker.sv
// Scoreboard bench for crc16_checker: directed frames, expected bytes/results queued at issue, popped by a monitor.
module tb_crc16_checker;

    localparam int CW = 2;

    logic        clk = 1'b0, nrst = 1'b0, init = 1'b0;
    logic [7:0]  seed = 8'h00, s_data = 8'h00;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_ready = 1'b1;
    logic        done, crc_ok, len_err;
    logic [15:0] crc_rx, crc_calc;
`ifdef CRC16_CHK_STATS_EN
    logic [CW-1:0] good_cnt, bad_cnt;
`endif

    crc16_checker #(.CNT_W(CW)) dut (
        .clk(clk), .nrst(nrst), .init(init), .seed(seed),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .done(done), .crc_ok(crc_ok), .len_err(len_err),
        .crc_rx(crc_rx), .crc_calc(crc_calc)
`ifdef CRC16_CHK_STATS_EN
        , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ok;
        logic        le;
        logic [15:0] rx;
        logic [15:0] calc;
        bit          calc_eq;
    } res_t;

    int         checks = 0, errors = 0;
    logic [8:0] exp_b[$];
    res_t       exp_r[$];
    int         exp_dc[$];
    logic [7:0] frm[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every consumed payload byte and every done pulse against the queues.
    always @(negedge clk) begin
        if (nrst) begin
            if (m_valid && m_ready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", m_data);
                end else begin
                    logic [8:0] e;
                    e = exp_b.pop_front();
                    chk("m_data", m_data, e[7:0]);
                    chk("m_last", m_last, e[8]);
                end
            end
            if (done) begin
                if (exp_r.size() == 0 || exp_dc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    res_t r;
                    r = exp_r.pop_front();
                    chk("crc_ok", crc_ok, r.ok);
                    chk("len_err", len_err, r.le);
                    chk("crc_rx", crc_rx, r.rx);
                    if (r.calc_eq)
                        chk("crc_calc", crc_calc, r.calc);
                    else begin
                        checks++;
                        if (crc_calc == r.calc) begin
                            errors++;
                            $display("FAIL crc_calc_differs actual=%0h expected=not_%0h", crc_calc, r.calc);
                        end
                    end
                    chk("done_cycle", cyc, exp_dc.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit last);
        bit ok;
        int n;
        ok = 1'b0; n = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        do begin
            @(negedge clk); ok = s_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 100);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout actual=0 expected=1");
        end else if (last)
            exp_dc.push_back(cyc + 1);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit with_last);
        for (int i = 0; i < n; i++)
            send(frm[i], with_last && (i == n - 1));
    endtask

    task automatic expect_payload(input int n);
        for (int i = 0; i < n - 2; i++)
            exp_b.push_back({(i == n - 3), frm[i]});
    endtask

    task automatic expect_res(input logic ok, input logic le, input logic [15:0] rx,
                              input logic [15:0] calc, input bit calc_eq);
        res_t r;
        r.ok = ok; r.le = le; r.rx = rx; r.calc = calc; r.calc_eq = calc_eq;
        exp_r.push_back(r);
    endtask

    task automatic load_good();
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
    endtask

    task automatic good_frame();
        load_good();
        expect_payload(11);
        expect_res(1'b1, 1'b0, 16'h31C3, 16'h31C3, 1'b1);
        send_frame(11, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_b.size() + exp_r.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_crc_rx", crc_rx, 16'h0000);
        chk("rst_crc_calc", crc_calc, 16'h0000);
        chk("rst_s_ready", s_ready, 1'b0);
        nrst = 1'b1;
        #1 chk("s_ready_before_edge", s_ready, 1'b0);
        @(posedge clk); #1;
        chk("s_ready_after_edge", s_ready, 1'b1);

        // 1: "123456789" + 0x31C3
        good_frame();
        wait_idle();

        // 2: corrupted payload byte
        load_good(); frm[4] = 8'h34;
        expect_payload(11);
        expect_res(1'b0, 1'b0, 16'h31C3, 16'h31C3, 1'b0);
        send_frame(11, 1'b1);
        wait_idle();

        // 3: short frame, then a good frame back to back
        frm[0] = 8'hAA; frm[1] = 8'h55;
        expect_res(1'b0, 1'b1, 16'h31C3, 16'h0000, 1'b1);
        send_frame(2, 1'b1);
        good_frame();
        wait_idle();

        // 4: consumer stall after first output
        fork
            good_frame();
            begin
                int n;
                n = 0;
                do begin @(posedge clk); #1; n++; end while (!m_valid && n < 100);
                m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_s_ready", s_ready, 1'b0);
                    chk("stall_m_valid", m_valid, 1'b1);
                    chk("stall_m_data", m_data, 8'h31);
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
        join
        wait_idle();

        // 5: abort after 4 bytes, then a full frame
        load_good();
        exp_b.push_back({1'b0, 8'h31});
        exp_b.push_back({1'b0, 8'h32});
        send_frame(4, 1'b0);
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        good_frame();
        wait_idle();

        // 5b: asynchronous reset mid-frame while a byte sits in the output register
        load_good();
        exp_b.push_back({1'b0, 8'h31});
        send_frame(4, 1'b0);
        chk("pre_rst_m_valid", m_valid, 1'b1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_m_data", m_data, 8'h00);
        chk("arst_crc_ok", crc_ok, 1'b0);
        chk("arst_crc_rx", crc_rx, 16'h0000);
        chk("arst_crc_calc", crc_calc, 16'h0000);
        chk("arst_s_ready", s_ready, 1'b0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        good_frame();
        wait_idle();

`ifdef CRC16_CHK_STATS_EN
        // 6: 4 good (one above) + 1 bad with 2-bit counters
        repeat (3) good_frame();
        load_good(); frm[4] = 8'h34;
        expect_payload(11);
        expect_res(1'b0, 1'b0, 16'h31C3, 16'h31C3, 1'b0);
        send_frame(11, 1'b1);
        wait_idle();
        chk("good_cnt", good_cnt, 2'd3);
        chk("bad_cnt", bad_cnt, 2'd1);
`endif

        chk("leftover_expectations", exp_b.size() + exp_r.size() + exp_dc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
